// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: starts one arithmetic unit on the latched
// operands, waits for its done pulse, and range-checks the result for display.
module calc_op_sequencer #(
  parameter int DATA_W         = 16,
  parameter int RES_W          = 32,
  parameter int RES_MAX        = 9999,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              clear,
  output logic [3:0]        unit_start,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  input  logic [3:0]        unit_done,
  input  logic [RES_W-1:0]  unit_result,
  output logic              busy,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  // Request handshake: op_valid and clear are one-cycle pulses, sampled only in
  // IDLE or HOLD (i.e. while busy is low); anything presented while busy is
  // dropped. Each unit gets a one-cycle unit_start and answers with a one-cycle
  // unit_done, whose cycle also carries the valid unit_result.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [RES_W-1:0] RES_HI = RES_W'(RES_MAX);
  localparam logic signed [RES_W-1:0] RES_LO = -RES_HI;

  state_t             r_state;
  logic [1:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_res;

  logic w_bad_op;
  logic w_div0;
  logic w_out_of_range;

  assign w_bad_op       = op_code[2];
  assign w_div0         = (op_code == 3'd3) && (operand_b == '0);
  assign w_out_of_range = ($signed(r_res) > RES_HI) || ($signed(r_res) < RES_LO);
  assign dbg_state      = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_cnt        <= '0;
      r_res        <= '0;
      unit_start   <= '0;
      unit_a       <= '0;
      unit_b       <= '0;
      busy         <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      unit_start <= '0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if ((r_state == S_HOLD) && clear) begin
            r_state      <= S_IDLE;
            result_valid <= 1'b0;
            result_out   <= '0;
            err_code     <= 2'd0;
          end else if (op_valid) begin
            r_op   <= op_code[1:0];
            unit_a <= operand_a;
            unit_b <= operand_b;
            result_out <= '0;
            // Bad codes and divide-by-zero are resolved here without touching a unit.
            if (w_bad_op || w_div0) begin
              r_state      <= S_HOLD;
              result_valid <= 1'b1;
              err_code     <= w_bad_op ? 2'd3 : 2'd1;
              busy         <= 1'b0;
            end else begin
              r_state      <= S_ISSUE;
              unit_start   <= 4'b0001 << op_code[1:0];
              result_valid <= 1'b0;
              err_code     <= 2'd0;
              busy         <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (unit_done[r_op]) begin
            r_res   <= unit_result;
            r_state <= S_CHECK;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= S_HOLD;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result_out   <= '0;
            err_code     <= 2'd3;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          r_state      <= S_HOLD;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          if (w_out_of_range) begin
            result_out <= '0;
            err_code   <= 2'd2;
          end else begin
            result_out <= r_res[DATA_W-1:0];
            err_code   <= 2'd0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
          result_out   <= '0;
          err_code     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: a table of single operations against a
// behavioural unit model, plus hand-written multi-cycle corner sequences.
module tb_calc_op_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        clear;
  logic [3:0]  unit_start;
  logic [15:0] unit_a;
  logic [15:0] unit_b;
  logic [3:0]  unit_done;
  logic [31:0] unit_result;
  logic        busy;
  logic [15:0] result_out;
  logic        result_valid;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  calc_op_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .operand_a(operand_a), .operand_b(operand_b), .clear(clear),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result), .busy(busy),
    .result_out(result_out), .result_valid(result_valid),
    .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // unit model: answers the started unit after m_delay cycles with m_res
  logic        m_en;
  int          m_delay;
  logic [31:0] m_res;
  logic [3:0]  m_done;
  logic [31:0] m_bus;
  logic [3:0]  stray;
  logic [31:0] stray_res;

  assign unit_done   = m_done | stray;
  assign unit_result = (|stray) ? stray_res : m_bus;

  initial begin
    m_done = '0;
    m_bus  = '0;
    forever begin
      @(posedge clk); #1;
      if (m_en && (|unit_start)) begin
        logic [3:0] who;
        logic [31:0] val;
        who = unit_start;
        val = m_res;
        repeat (m_delay) @(posedge clk);
        #1;
        m_done = who;
        m_bus  = val;
        @(posedge clk); #1;
        m_done = '0;
      end
    end
  end

  int         start_cnt;
  logic [3:0] last_start;
  initial begin
    start_cnt  = 0;
    last_start = '0;
  end
  always @(negedge clk) begin
    if (|unit_start) begin
      start_cnt  <= start_cnt + 1;
      last_start <= unit_start;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // driver tasks (all entered and left 1 time unit after a rising edge)
  task automatic send_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    op_code   = op;
    operand_a = a;
    operand_b = b;
    op_valid  = 1'b1;
    @(posedge clk); #1;
    op_valid  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_hold(output int edges, output logic ok);
    edges = 0;
    ok    = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] mres;
    int          dly;
    logic [1:0]  err;
    logic [15:0] res;
    logic        started;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int          lat;
  logic        ok;
  int          s0;
  int          bcount;
  logic [17:0] expv;

  initial begin
    vecs[0]  = '{3'd0, 16'd123,     16'(-45),   32'd78,        3, 2'd0, 16'd78,   1'b1};
    vecs[1]  = '{3'd2, 16'd999,     16'd999,    32'd998001,    2, 2'd2, 16'd0,    1'b1};
    vecs[2]  = '{3'd2, 16'(-99),    16'd99,     32'(-9801),    1, 2'd0, 16'hD9B7, 1'b1};
    vecs[3]  = '{3'd3, 16'd500,     16'd0,      32'd0,         1, 2'd1, 16'd0,    1'b0};
    vecs[4]  = '{3'd6, 16'd5,       16'd5,      32'd0,         1, 2'd3, 16'd0,    1'b0};
    vecs[5]  = '{3'd1, 16'd10,      16'd20,     32'(-10),      1, 2'd0, 16'hFFF6, 1'b1};
    vecs[6]  = '{3'd3, 16'd100,     16'd7,      32'd14,        4, 2'd0, 16'd14,   1'b1};
    vecs[7]  = '{3'd0, 16'd5000,    16'd4999,   32'd9999,      1, 2'd0, 16'd9999, 1'b1};
    vecs[8]  = '{3'd1, 16'(-5000),  16'd5000,   32'(-10000),   2, 2'd2, 16'd0,    1'b1};
    vecs[9]  = '{3'd1, 16'd1,       16'd10000,  32'(-9999),    1, 2'd0, 16'hD8F1, 1'b1};
    vecs[10] = '{3'd0, 16'd9999,    16'd1,      32'd10000,     1, 2'd2, 16'd0,    1'b1};

    reset = 1'b1; op_valid = 1'b0; op_code = '0; operand_a = '0; operand_b = '0;
    clear = 1'b0; stray = '0; stray_res = '0; m_en = 1'b0; m_delay = 1; m_res = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_result_valid", result_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_unit_start", unit_start, 0);
    chk("reset_err", err_code, 0);
    chk("reset_result", result_out, 0);

    // table-driven single operations
    for (int i = 0; i < NV; i++) begin
      do_clear();
      m_en    = 1'b1;
      m_delay = vecs[i].dly;
      m_res   = vecs[i].mres;
      s0      = start_cnt;
      exp_q.push_back({vecs[i].err, vecs[i].res});
      send_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_hold(lat, ok);
      chk("vec_reached_hold", ok, 1);
      expv = exp_q.pop_front();
      chk("vec_err", err_code, expv[17:16]);
      chk("vec_result", result_out, expv[15:0]);
      chk("vec_start_count", start_cnt - s0, vecs[i].started);
      if (vecs[i].started) chk("vec_start_onehot", last_start, 32'd1 << vecs[i].op);
      chk("vec_latency", lat, vecs[i].started ? vecs[i].dly + 2 : 0);
    end

    // timeout on sub, then a late done in HOLD
    do_clear();
    m_en = 1'b0;
    s0 = start_cnt;
    send_op(3'd1, 16'd50, 16'd20);
    bcount = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy) break;
      bcount++;
      @(posedge clk); #1;
    end
    chk("timeout_busy_cycles", bcount, 1025);
    chk("timeout_err", err_code, 3);
    chk("timeout_result", result_out, 0);
    chk("timeout_valid", result_valid, 1);
    chk("timeout_starts", start_cnt - s0, 1);
    stray = 4'b0010; stray_res = 32'd42;
    @(posedge clk); #1;
    stray = '0;
    @(posedge clk); #1;
    chk("late_done_err", err_code, 3);
    chk("late_done_result", result_out, 0);
    chk("late_done_busy", busy, 0);

    // stray dones: own unit during ISSUE, other unit during WAIT
    do_clear();
    m_en = 1'b1; m_delay = 4; m_res = 32'd7;
    send_op(3'd0, 16'd3, 16'd4);
    stray = 4'b0001; stray_res = 32'd1111;
    @(posedge clk); #1;
    stray = 4'b0100; stray_res = 32'd5555;
    @(posedge clk); #1;
    stray = '0;
    wait_hold(lat, ok);
    chk("stray_hold", ok, 1);
    chk("stray_result", result_out, 7);
    chk("stray_err", err_code, 0);
    chk("stray_latency", lat, 4);

    // op_valid while busy is dropped
    do_clear();
    m_delay = 5; m_res = 32'd33;
    s0 = start_cnt;
    send_op(3'd0, 16'd11, 16'd22);
    @(posedge clk); #1;
    send_op(3'd2, 16'd100, 16'd100);
    chk("busy_drop_unit_a", unit_a, 11);
    chk("busy_drop_unit_b", unit_b, 22);
    wait_hold(lat, ok);
    chk("busy_drop_result", result_out, 33);
    chk("busy_drop_starts", start_cnt - s0, 1);

    // new op straight from HOLD, no IDLE visit
    m_delay = 1; m_res = 32'd5;
    s0 = start_cnt;
    send_op(3'd1, 16'd8, 16'd3);
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_valid", result_valid, 0);
    wait_hold(lat, ok);
    chk("hold_restart_result", result_out, 5);
    chk("hold_restart_onehot", last_start, 4'b0010);
    chk("hold_restart_starts", start_cnt - s0, 1);

    // clear beats op_valid in HOLD
    s0 = start_cnt;
    clear = 1'b1; op_valid = 1'b1; op_code = 3'd0; operand_a = 16'd1; operand_b = 16'd1;
    @(posedge clk); #1;
    clear = 1'b0; op_valid = 1'b0;
    chk("clear_wins_valid", result_valid, 0);
    chk("clear_wins_busy", busy, 0);
    chk("clear_wins_err", err_code, 0);
    chk("clear_wins_result", result_out, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_wins_no_start", start_cnt - s0, 0);

    // asynchronous reset during ISSUE
    m_en = 1'b0;
    send_op(3'd0, 16'd2, 16'd2);
    chk("rst_issue_start_high", unit_start, 4'b0001);
    #3 reset = 1'b1;
    #1;
    chk("rst_async_start", unit_start, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_unit_a", unit_a, 0);
    chk("rst_async_valid", result_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_en = 1'b1; m_delay = 2; m_res = 32'd4;
    send_op(3'd0, 16'd2, 16'd2);
    wait_hold(lat, ok);
    chk("post_rst_hold", ok, 1);
    chk("post_rst_result", result_out, 4);
    chk("post_rst_err", err_code, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Sequences one arithmetic operation on the two confirmed calculator operands.
- Takes operand A, operand B and an op code from the input stage.
- Issues a start pulse to the selected arithmetic unit, waits for its done handshake, then range-checks the result.
- Holds the result and an error code for the 7-segment display path until cleared or until the next operation.

Parameters:
- DATA_W, 16, operand and displayed-result width (two's complement).
- RES_W, 32, width of the shared unit result bus (signed).
- RES_MAX, 9999, largest displayable magnitude; a result is out of range when |result| > RES_MAX.
- TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before the operation is abandoned.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  single-cycle request pulse: operands and op_code are valid this cycle.
- op_code  input  3  operation select: 0 add, 1 sub, 2 mul, 3 div; 4..7 are invalid codes.
- operand_a  input  DATA_W  signed operand A.
- operand_b  input  DATA_W  signed operand B.
- clear  input  1  single-cycle pulse: drop the held result and return to IDLE.
- unit_start  output  4  one-hot start pulse, indexed by op_code.
- unit_a  output  DATA_W  operand A as presented to the units.
- unit_b  output  DATA_W  operand B as presented to the units.
- unit_done  input  4  per-unit done pulse.
- unit_result  input  RES_W  shared signed result bus; valid in the cycle the selected unit's done is high.
- busy  output  1  high in ISSUE, WAIT and CHECK.
- result_out  output  DATA_W  signed result for the display path.
- result_valid  output  1  high while in HOLD.
- err_code  output  2  0 ok, 1 divide by zero, 2 overflow, 3 invalid op or timeout.

Behaviour:
- Reset: asynchronous. All outputs go to 0 and the FSM goes to IDLE. unit_start falls immediately, so it is cut off even mid-pulse.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, CHECK, HOLD.

IDLE:
- On op_valid, latch op_code, operand_a and operand_b into internal registers. unit_a and unit_b then show the latched values.
- op_code > 3: go to HOLD with err_code=3 and result_out=0.
- op_code == 3 and operand_b == 0: go to HOLD with err_code=1 and result_out=0. No unit is started.
- Otherwise go to ISSUE.

ISSUE (exactly 1 cycle):
- unit_start[op] = 1; all other bits are 0.
- Clear the timeout counter, then go to WAIT.

WAIT:
- unit_done[op] = 1: capture unit_result and go to CHECK.
- Done pulses from other units are ignored.
- Any unit_done arriving during the ISSUE cycle is ignored.
- The counter increments every WAIT cycle. When it reaches TIMEOUT_CYCLES-1 with no done, go to HOLD with err_code=3 and result_out=0.

CHECK (1 cycle):
- Captured result < -RES_MAX or > RES_MAX: err_code=2, result_out=0.
- Otherwise err_code=0 and result_out = captured[DATA_W-1:0].
- Go to HOLD.

HOLD:
- result_valid=1; result_out and err_code are stable.
- op_valid: latch the new request and apply the same checks as in IDLE. result_valid drops on the next cycle.
- clear: go to IDLE; result_valid, result_out and err_code go to 0.
- If clear and op_valid arrive in the same cycle, clear wins.

Handshake and timing rules:
- op_valid and clear are ignored while busy; no queueing.
- unit_a and unit_b are held constant from ISSUE through the end of WAIT.
- Latency: op_valid at edge 0 → unit_start high in cycle 1 → done earliest in cycle 2 → CHECK in cycle 3 → result_valid in cycle 4.
- Immediate error (invalid op or div0): result_valid is high in cycle 1.

Test Plan:
1. Add: A=123, B=-45, op 0; the add model returns done 3 cycles after start → exactly one unit_start=0001 pulse; result_valid high, result_out=78, err_code=0; latency 6 cycles from op_valid.
2. Overflow: A=999, B=999, op 2, result bus 998001 → err_code=2, result_out=0. Repeat with A=-99, B=99 → result_out=-9801 (0xD9B7), err_code=0.
3. Divide by zero: A=500, B=0, op 3 → unit_start never asserts; result_valid next cycle; err_code=1. Invalid op: op_code=6 → err_code=3, no start.
4. Timeout: op 1 with the model never raising done → busy for TIMEOUT_CYCLES WAIT cycles, then err_code=3. A late done after HOLD is entered is ignored. A stray unit_done[2] during WAIT of op 0 is ignored.
5. Busy and HOLD rules: op_valid pulses during WAIT are dropped (operands unchanged). In HOLD, a new op_valid restarts the sequence with no IDLE visit. Simultaneous clear+op_valid in HOLD → IDLE, no unit_start.
6. Reset mid-operation: assert reset during the ISSUE cycle → unit_start falls without waiting for a clock edge; all outputs are 0; after release the next op_valid completes normally.
